alu_operand_stage: RTL and testbench

Registered operand-preparation stage between register-file read and the ALU: selects and extends operands, resolves RAW hazards by forwarding from later pipeline stages, and holds the result in a valid/ready pipeline register. It generalises operand selection to parametrised data/immediate widths and N forwarding sources. It adds stall-on-pending-producer, flush, and back-pressure.

---
 rtl/alu_operand_pkg.sv | 20 ++
 rtl/alu_operand_stage_fwd_select.sv | 38 +++
 rtl/alu_operand_stage.sv | 172 +++++++++++++++++
 tb/tb_alu_operand_stage.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_operand_pkg.sv
// Shared types and constants for the ALU operand-preparation stage.
package alu_operand_pkg;

    typedef enum logic [1:0] {
        B_RT      = 2'd0,
        B_IMM_EXT = 2'd1,
        B_IMM_HI  = 2'd2,
        B_ZERO    = 2'd3
    } alu_src_b_e;

    typedef enum logic [1:0] {
        SH_SHAMT = 2'd0,
        SH_REG   = 2'd1,
        SH_HALF  = 2'd2,
        SH_ZERO  = 2'd3
    } shamt_sel_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage : alu_operand_pkg

// File: rtl/alu_operand_stage_fwd_select.sv
// Priority forwarding mux for one source operand; also flags a pending-producer hazard.
module fwd_select
    import alu_operand_pkg::*;
#(
    parameter int DATA_BITS = 32,
    parameter int NUM_FWD   = 2
) (
    input  logic [4:0]               src_addr,
    input  logic                     use_src,
    input  logic [DATA_BITS-1:0]     reg_data,
    input  logic [NUM_FWD-1:0]       fwd_we,
    input  logic [NUM_FWD-1:0]       fwd_busy,
    input  logic [NUM_FWD*5-1:0]     fwd_addr,
    input  logic [NUM_FWD*DATA_BITS-1:0] fwd_data,
    output logic [DATA_BITS-1:0]     fwd_value,
    output logic                     hazard
);

    logic found_s;

    // Lowest-index matching writer wins; register 0 is never forwarded.
    always_comb begin
        fwd_value = reg_data;
        hazard    = 1'b0;
        found_s   = 1'b0;
        for (int i = 0; i < NUM_FWD; i++) begin
            if (!found_s && fwd_we[i] && (fwd_addr[i*5 +: 5] == src_addr)
                && (src_addr != REG_ZERO)) begin
                found_s   = 1'b1;
                fwd_value = fwd_data[i*DATA_BITS +: DATA_BITS];
                hazard    = fwd_busy[i] & use_src;
            end else begin
                found_s   = found_s;
            end
        end
    end

endmodule : fwd_select

// File: rtl/alu_operand_stage.sv
// Operand-preparation pipeline stage: forwarding, operand muxing and a valid/ready output register.
module alu_operand_stage
    import alu_operand_pkg::*;
#(
    parameter int DATA_BITS  = 32,
    parameter int IMM_BITS   = 16,
    parameter int SHAMT_BITS = 5,
    parameter int NUM_FWD    = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          flush,
    input  logic [DATA_BITS-1:0]          reg_out1,
    input  logic [DATA_BITS-1:0]          reg_out2,
    input  logic [4:0]                    rs_addr,
    input  logic [4:0]                    rt_addr,
    input  logic                          use_rs,
    input  logic                          use_rt,
    input  logic [IMM_BITS-1:0]           immediate,
    input  logic [SHAMT_BITS-1:0]         shamt_in,
    input  logic [1:0]                    alu_src_b,
    input  logic [1:0]                    shamt_sel,
    input  logic                          signed_ext,
    input  logic [NUM_FWD-1:0]            fwd_we,
    input  logic [NUM_FWD-1:0]            fwd_busy,
    input  logic [NUM_FWD*5-1:0]          fwd_addr,
    input  logic [NUM_FWD*DATA_BITS-1:0]  fwd_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_BITS-1:0]          alu_a,
    output logic [DATA_BITS-1:0]          alu_b,
    output logic [DATA_BITS-1:0]          store_data,
    output logic [SHAMT_BITS-1:0]         shamt_out
);

    // Wide enough to hold {imm, zeros} before fitting it to the datapath.
    localparam int HI_W = (2*IMM_BITS > DATA_BITS) ? 2*IMM_BITS : DATA_BITS;

    logic [DATA_BITS-1:0]  fwd_rs_s;
    logic [DATA_BITS-1:0]  fwd_rt_s;
    logic                  haz_rs_s;
    logic                  haz_rt_s;
    logic                  hazard_s;
    logic                  in_ready_s;
    logic                  accept_s;
    logic [DATA_BITS-1:0]  imm_ext_s;
    logic [HI_W-1:0]       imm_hi_wide_s;
    logic [DATA_BITS-1:0]  alu_b_sel_s;
    logic [SHAMT_BITS-1:0] shamt_sel_s;

    logic                  out_valid_d, out_valid_q;
    logic [DATA_BITS-1:0]  alu_a_d, alu_a_q;
    logic [DATA_BITS-1:0]  alu_b_d, alu_b_q;
    logic [DATA_BITS-1:0]  store_data_d, store_data_q;
    logic [SHAMT_BITS-1:0] shamt_out_d, shamt_out_q;

    fwd_select #(
        .DATA_BITS (DATA_BITS),
        .NUM_FWD   (NUM_FWD)
    ) u_fwd_rs (
        .src_addr  (rs_addr),
        .use_src   (use_rs),
        .reg_data  (reg_out1),
        .fwd_we    (fwd_we),
        .fwd_busy  (fwd_busy),
        .fwd_addr  (fwd_addr),
        .fwd_data  (fwd_data),
        .fwd_value (fwd_rs_s),
        .hazard    (haz_rs_s)
    );

    fwd_select #(
        .DATA_BITS (DATA_BITS),
        .NUM_FWD   (NUM_FWD)
    ) u_fwd_rt (
        .src_addr  (rt_addr),
        .use_src   (use_rt),
        .reg_data  (reg_out2),
        .fwd_we    (fwd_we),
        .fwd_busy  (fwd_busy),
        .fwd_addr  (fwd_addr),
        .fwd_data  (fwd_data),
        .fwd_value (fwd_rt_s),
        .hazard    (haz_rt_s)
    );

    // Handshake: stall on a pending producer or when the held op cannot retire.
    always_comb begin
        hazard_s   = haz_rs_s | haz_rt_s;
        in_ready_s = (~out_valid_q | out_ready) & ~hazard_s;
        accept_s   = in_valid & in_ready_s & ~flush;
    end

    // Immediate extension and operand/shift-amount selection.
    always_comb begin
        if (signed_ext) begin
            imm_ext_s = {{(DATA_BITS-IMM_BITS){immediate[IMM_BITS-1]}}, immediate};
        end else begin
            imm_ext_s = {{(DATA_BITS-IMM_BITS){1'b0}}, immediate};
        end
        imm_hi_wide_s = HI_W'({immediate, {IMM_BITS{1'b0}}});

        case (alu_src_b_e'(alu_src_b))
            B_RT:      alu_b_sel_s = fwd_rt_s;
            B_IMM_EXT: alu_b_sel_s = imm_ext_s;
            B_IMM_HI:  alu_b_sel_s = imm_hi_wide_s[DATA_BITS-1:0];
            B_ZERO:    alu_b_sel_s = {DATA_BITS{1'b0}};
            default:   alu_b_sel_s = {DATA_BITS{1'b0}};
        endcase

        case (shamt_sel_e'(shamt_sel))
            SH_SHAMT: shamt_sel_s = shamt_in;
            SH_REG:   shamt_sel_s = fwd_rs_s[SHAMT_BITS-1:0];
            SH_HALF:  shamt_sel_s = SHAMT_BITS'(IMM_BITS);
            SH_ZERO:  shamt_sel_s = {SHAMT_BITS{1'b0}};
            default:  shamt_sel_s = {SHAMT_BITS{1'b0}};
        endcase
    end

    // Next state: flush beats accept beats retire; data only moves on accept.
    always_comb begin
        out_valid_d  = out_valid_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        store_data_d = store_data_q;
        shamt_out_d  = shamt_out_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (accept_s) begin
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
        if (accept_s) begin
            alu_a_d      = fwd_rs_s;
            alu_b_d      = alu_b_sel_s;
            store_data_d = fwd_rt_s;
            shamt_out_d  = shamt_sel_s;
        end else begin
            alu_a_d      = alu_a_q;
        end
    end

    // Output pipeline register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            alu_a_q      <= {DATA_BITS{1'b0}};
            alu_b_q      <= {DATA_BITS{1'b0}};
            store_data_q <= {DATA_BITS{1'b0}};
            shamt_out_q  <= {SHAMT_BITS{1'b0}};
        end else begin
            out_valid_q  <= out_valid_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            store_data_q <= store_data_d;
            shamt_out_q  <= shamt_out_d;
        end
    end

    assign in_ready   = in_ready_s;
    assign out_valid  = out_valid_q;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign store_data = store_data_q;
    assign shamt_out  = shamt_out_q;

endmodule : alu_operand_stage

// File: tb/tb_alu_operand_stage.sv
// Directed, table-driven bench for alu_operand_stage plus hand-written stall/flush/reset sequences.
module tb_alu_operand_stage;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        flush;
    logic [31:0] reg_out1, reg_out2;
    logic [4:0]  rs_addr, rt_addr;
    logic        use_rs, use_rt;
    logic [15:0] immediate;
    logic [4:0]  shamt_in;
    logic [1:0]  alu_src_b, shamt_sel;
    logic        signed_ext;
    logic [1:0]  fwd_we, fwd_busy;
    logic [9:0]  fwd_addr;
    logic [63:0] fwd_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] alu_a, alu_b, store_data;
    logic [4:0]  shamt_out;

    int total;
    int bad;

    alu_operand_stage #(
        .DATA_BITS (32), .IMM_BITS (16), .SHAMT_BITS (5), .NUM_FWD (2)
    ) dut (
        .clk (clk), .rst_n (rst_n), .in_valid (in_valid), .in_ready (in_ready),
        .flush (flush), .reg_out1 (reg_out1), .reg_out2 (reg_out2),
        .rs_addr (rs_addr), .rt_addr (rt_addr), .use_rs (use_rs), .use_rt (use_rt),
        .immediate (immediate), .shamt_in (shamt_in), .alu_src_b (alu_src_b),
        .shamt_sel (shamt_sel), .signed_ext (signed_ext), .fwd_we (fwd_we),
        .fwd_busy (fwd_busy), .fwd_addr (fwd_addr), .fwd_data (fwd_data),
        .out_valid (out_valid), .out_ready (out_ready), .alu_a (alu_a),
        .alu_b (alu_b), .store_data (store_data), .shamt_out (shamt_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [31:0] r1;
        logic [31:0] r2;
        logic [15:0] imm;
        logic [4:0]  sh_in;
        logic [1:0]  srcb;
        logic [1:0]  shsel;
        logic        sext;
        logic [1:0]  we;
        logic [4:0]  a0;
        logic [4:0]  a1;
        logic [31:0] d0;
        logic [31:0] d1;
        logic [31:0] ea;
        logic [31:0] eb;
        logic [31:0] es;
        logic [4:0]  esh;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_a"}, alu_a, 32'd0);
        chk({tag, "_b"}, alu_b, 32'd0);
        chk({tag, "_store"}, store_data, 32'd0);
        chk({tag, "_shamt"}, {27'd0, shamt_out}, 32'd0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b1;
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        reg_out1 = 32'd0; reg_out2 = 32'd0; rs_addr = 5'd0; rt_addr = 5'd0;
        use_rs = 1'b1; use_rt = 1'b1; immediate = 16'd0; shamt_in = 5'd0;
        alu_src_b = 2'd0; shamt_sel = 2'd0; signed_ext = 1'b0;
        fwd_we = 2'b00; fwd_busy = 2'b00; fwd_addr = 10'd0; fwd_data = 64'd0;

        //           rs    rt    r1      r2      imm       shin  srcb  shsel sext  we     a0    a1    d0     d1     ea     eb            es     esh
        vecs[0] = '{5'd1, 5'd2, 32'h27, 32'h55, 16'h8001, 5'd0, 2'd1, 2'd1, 1'b1, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 32'h27, 32'hFFFF8001, 32'h55, 5'd7};
        vecs[1] = '{5'd1, 5'd2, 32'h27, 32'h55, 16'h8001, 5'd0, 2'd1, 2'd2, 1'b0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 32'h27, 32'h00008001, 32'h55, 5'd16};
        vecs[2] = '{5'd1, 5'd2, 32'h27, 32'h55, 16'h8001, 5'd9, 2'd2, 2'd0, 1'b1, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 32'h27, 32'h80010000, 32'h55, 5'd9};
        vecs[3] = '{5'd1, 5'd2, 32'h27, 32'h55, 16'h8001, 5'd9, 2'd3, 2'd3, 1'b1, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 32'h27, 32'h0,        32'h55, 5'd0};
        vecs[4] = '{5'd3, 5'd2, 32'h27, 32'h55, 16'h8001, 5'd0, 2'd0, 2'd1, 1'b1, 2'b11, 5'd3, 5'd3, 32'hA, 32'hB, 32'hA,  32'h55,       32'h55, 5'd10};
        vecs[5] = '{5'd0, 5'd4, 32'h27, 32'h66, 16'h8001, 5'd0, 2'd0, 2'd0, 1'b1, 2'b11, 5'd0, 5'd0, 32'hA, 32'hB, 32'h27, 32'h66,       32'h66, 5'd0};
        vecs[6] = '{5'd3, 5'd3, 32'h27, 32'h55, 16'h8001, 5'd0, 2'd0, 2'd1, 1'b1, 2'b10, 5'd3, 5'd3, 32'hA, 32'hB, 32'hB,  32'hB,        32'hB,  5'd11};
        vecs[7] = '{5'd3, 5'd7, 32'h27, 32'h55, 16'h8001, 5'd31, 2'd0, 2'd0, 1'b1, 2'b11, 5'd7, 5'd3, 32'hA, 32'hB, 32'hB,  32'hA,        32'hA,  5'd31};

        // Reset is asynchronous: outputs clear before any clock edge.
        #1 rst_n = 1'b0;
        #2;
        chk_zero_outputs("reset_init");
        step();
        rst_n = 1'b1;
        step();

        // Table: back-to-back ops at full throughput.
        for (int i = 0; i < 8; i++) begin
            rs_addr = vecs[i].rs; rt_addr = vecs[i].rt;
            reg_out1 = vecs[i].r1; reg_out2 = vecs[i].r2;
            immediate = vecs[i].imm; shamt_in = vecs[i].sh_in;
            alu_src_b = vecs[i].srcb; shamt_sel = vecs[i].shsel;
            signed_ext = vecs[i].sext; fwd_we = vecs[i].we;
            fwd_addr = {vecs[i].a1, vecs[i].a0}; fwd_data = {vecs[i].d1, vecs[i].d0};
            in_valid = 1'b1;
            #1;
            chk($sformatf("v%0d_in_ready", i), {31'd0, in_ready}, 32'd1);
            step();
            chk($sformatf("v%0d_valid", i), {31'd0, out_valid}, 32'd1);
            chk($sformatf("v%0d_alu_a", i), alu_a, vecs[i].ea);
            chk($sformatf("v%0d_alu_b", i), alu_b, vecs[i].eb);
            chk($sformatf("v%0d_store", i), store_data, vecs[i].es);
            chk($sformatf("v%0d_shamt", i), {27'd0, shamt_out}, {27'd0, vecs[i].esh});
        end

        // Load-use stall on rt from busy youngest source.
        rs_addr = 5'd1; rt_addr = 5'd5; reg_out1 = 32'h11; reg_out2 = 32'h22;
        alu_src_b = 2'd0; shamt_sel = 2'd0; shamt_in = 5'd0;
        fwd_we = 2'b01; fwd_busy = 2'b01; fwd_addr = {5'd0, 5'd5}; fwd_data = {32'h0, 32'hDEAD};
        #1;
        chk("stall_in_ready_0", {31'd0, in_ready}, 32'd0);
        step();
        chk("stall_in_ready_1", {31'd0, in_ready}, 32'd0);
        chk("stall_retired", {31'd0, out_valid}, 32'd0);
        step();
        chk("stall_in_ready_2", {31'd0, in_ready}, 32'd0);
        use_rt = 1'b0;
        #1;
        chk("unused_rt_no_hazard", {31'd0, in_ready}, 32'd1);
        use_rt = 1'b1;
        fwd_we = 2'b11; fwd_busy = 2'b10; fwd_addr = {5'd5, 5'd5};
        #1;
        chk("shadowed_busy_no_hazard", {31'd0, in_ready}, 32'd1);
        fwd_we = 2'b01; fwd_busy = 2'b00; fwd_data = {32'h0, 32'h1234};
        #1;
        chk("stall_release_ready", {31'd0, in_ready}, 32'd1);
        step();
        chk("stall_valid", {31'd0, out_valid}, 32'd1);
        chk("stall_store", store_data, 32'h1234);
        fwd_we = 2'b00;

        // Back-pressure: first op must stay put, next op waits.
        reg_out1 = 32'h111; rs_addr = 5'd1;
        step();
        chk("bp_first_a", alu_a, 32'h111);
        out_ready = 1'b0;
        reg_out1 = 32'h222;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("bp_in_ready_%0d", c), {31'd0, in_ready}, 32'd0);
            step();
            chk($sformatf("bp_hold_a_%0d", c), alu_a, 32'h111);
            chk($sformatf("bp_hold_valid_%0d", c), {31'd0, out_valid}, 32'd1);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", {31'd0, in_ready}, 32'd1);
        step();
        chk("bp_next_a", alu_a, 32'h222);
        chk("bp_next_valid", {31'd0, out_valid}, 32'd1);

        // Flush drops held and incoming op.
        reg_out1 = 32'h333; flush = 1'b1;
        step();
        chk("flush_valid", {31'd0, out_valid}, 32'd0);
        flush = 1'b0; in_valid = 1'b0;
        step();
        chk("flush_idle_valid", {31'd0, out_valid}, 32'd0);
        chk("flush_not_captured", alu_a, 32'h222);

        // Load an op, then reset in the middle of a stall.
        in_valid = 1'b1; reg_out1 = 32'h27; shamt_sel = 2'd1; alu_src_b = 2'd1;
        immediate = 16'h8001; signed_ext = 1'b1;
        step();
        chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        chk("pre_rst_shamt", {27'd0, shamt_out}, 32'd7);
        out_ready = 1'b0;
        rt_addr = 5'd5; fwd_we = 2'b01; fwd_busy = 2'b01; fwd_addr = {5'd0, 5'd5};
        step();
        #2 rst_n = 1'b0;
        #1;
        chk_zero_outputs("reset_mid");
        step();
        rst_n = 1'b1;
        #1;
        chk("post_rst_hazard_ready", {31'd0, in_ready}, 32'd0);
        fwd_busy = 2'b00;
        #1;
        chk("post_rst_ready", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b0;
        step();
        chk("post_rst_idle_valid", {31'd0, out_valid}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_alu_operand_stage
